// File: rtl/paddle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : paddle_controller
//  Description : Converts one player's raw up/down push-buttons into the
//                paddle's cell range on an LED column. Buttons are
//                synchronised, debounced and auto-repeated. The paddle is
//                clamped to the column and can be frozen or re-centred.
//  Ports       : clk, rst (async, active-high)
//                btn_up, btn_down  raw asynchronous buttons
//                freeze            hold position, FSM parked in IDLE
//                center            one-cycle re-centre request
//                state_left        lowest lit cell (registered)
//                state_right       highest lit cell (registered)
//                moved             pulse in the cycle after a position change
//  Revision    : 1.0 - initial release
// ============================================================================
module paddle_controller #(
    parameter int WIDTH         = 4,
    parameter int BIT_WIDTH     = 2,
    parameter int PADDLE_LEN    = 2,
    parameter int DEBOUNCE      = 4,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 freeze,
    input  logic                 center,
    output logic [BIT_WIDTH-1:0] state_left,
    output logic [BIT_WIDTH-1:0] state_right,
    output logic                 moved
);

    localparam logic [BIT_WIDTH-1:0] c_MAX_LEFT = BIT_WIDTH'(WIDTH - PADDLE_LEN);
    localparam logic [BIT_WIDTH-1:0] c_CPOS     = BIT_WIDTH'((WIDTH - PADDLE_LEN) / 2);
    localparam logic [BIT_WIDTH-1:0] c_LEN_M1   = BIT_WIDTH'(PADDLE_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] c_DEB_LAST = CNT_WIDTH'(DEBOUNCE - 1);
    localparam logic [CNT_WIDTH-1:0] c_DLY_LAST = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] c_PER_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);

    // Direction codes: bit 0 = up, bit 1 = down, matching the button vector.
    localparam logic [1:0] c_DIR_NONE = 2'b00;
    localparam logic [1:0] c_DIR_UP   = 2'b01;
    localparam logic [1:0] c_DIR_DOWN = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser and debounce, index 0 = up, index 1 = down
    // ------------------------------------------------------------------
    logic [1:0]           w_raw;
    logic [1:0]           r_meta;
    logic [1:0]           r_sync;
    logic [1:0]           r_deb;
    logic [CNT_WIDTH-1:0] r_dcnt [2];

    assign w_raw = {btn_down, btn_up};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
            r_deb  <= '0;
            for (int i = 0; i < 2; i++) r_dcnt[i] <= '0;
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
            for (int i = 0; i < 2; i++) begin
                if (r_sync[i] == r_deb[i]) begin
                    r_dcnt[i] <= '0;
                end else if (r_dcnt[i] == c_DEB_LAST) begin
                    r_deb[i]  <= r_sync[i];
                    r_dcnt[i] <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + 1'b1;
                end
            end
        end
    end

    // Both buttons held cancels out to no direction.
    logic [1:0] w_dir;
    assign w_dir = (r_deb == 2'b11) ? c_DIR_NONE : r_deb;

    // ------------------------------------------------------------------
    // Candidate position for a step in the current direction, clamped.
    // ------------------------------------------------------------------
    logic [BIT_WIDTH-1:0] w_step_left;

    always_comb begin
        w_step_left = state_left;
        if (w_dir == c_DIR_UP && state_left != c_MAX_LEFT)
            w_step_left = state_left + 1'b1;
        else if (w_dir == c_DIR_DOWN && state_left != '0)
            w_step_left = state_left - 1'b1;
    end

    // ------------------------------------------------------------------
    // Repeat FSM and position registers
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [1:0]           r_dir_lat;
    logic [CNT_WIDTH-1:0] r_rcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dir_lat   <= c_DIR_NONE;
            r_rcnt      <= '0;
            state_left  <= c_CPOS;
            state_right <= c_CPOS + c_LEN_M1;
            moved       <= 1'b0;
        end else begin
            moved <= 1'b0;
            if (center) begin
                r_state     <= S_IDLE;
                state_left  <= c_CPOS;
                state_right <= c_CPOS + c_LEN_M1;
                moved       <= (state_left != c_CPOS);
            end else if (freeze) begin
                // Parked in IDLE so a still-held button steps on release.
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_dir != c_DIR_NONE) begin
                            state_left  <= w_step_left;
                            state_right <= w_step_left + c_LEN_M1;
                            moved       <= (w_step_left != state_left);
                            r_dir_lat   <= w_dir;
                            r_rcnt      <= c_DLY_LAST;
                            r_state     <= S_HOLD;
                        end
                    end
                    S_HOLD, S_REPEAT: begin
                        if (w_dir != r_dir_lat) begin
                            // Release or reversal: one IDLE cycle, no step.
                            r_state <= S_IDLE;
                        end else if (r_rcnt == '0) begin
                            state_left  <= w_step_left;
                            state_right <= w_step_left + c_LEN_M1;
                            moved       <= (w_step_left != state_left);
                            r_rcnt      <= c_PER_LAST;
                            r_state     <= S_REPEAT;
                        end else begin
                            r_rcnt <= r_rcnt - 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_paddle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_paddle_controller
//  Description : Directed self-checking bench for paddle_controller. One
//                instance uses default parameters (4 cells), the other an
//                8-cell column for the freeze / auto-repeat sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_paddle_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_up, a_dn, a_frz, a_ctr;
    logic [1:0] a_left, a_right;
    logic       a_moved;
    logic       b_up, b_dn, b_frz, b_ctr;
    logic [2:0] b_left, b_right;
    logic       b_moved;

    int total = 0;
    int bad   = 0;

    paddle_controller dut_a (
        .clk         (clk),
        .rst         (rst),
        .btn_up      (a_up),
        .btn_down    (a_dn),
        .freeze      (a_frz),
        .center      (a_ctr),
        .state_left  (a_left),
        .state_right (a_right),
        .moved       (a_moved)
    );

    paddle_controller #(
        .WIDTH      (8),
        .BIT_WIDTH  (3),
        .PADDLE_LEN (2)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .btn_up      (b_up),
        .btn_down    (b_dn),
        .freeze      (b_frz),
        .center      (b_ctr),
        .state_left  (b_left),
        .state_right (b_right),
        .moved       (b_moved)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Sample 1 time unit after the rising edge; inputs are changed here too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b0;
        a_up = 1'b0; a_dn = 1'b0; a_frz = 1'b0; a_ctr = 1'b0;
        b_up = 1'b0; b_dn = 1'b0; b_frz = 1'b0; b_ctr = 1'b0;
        #1 rst = 1'b1;
        #1;
        // Asynchronous reset, before any clock edge.
        check("rst_a_left",  32'(a_left),  1);
        check("rst_a_right", 32'(a_right), 2);
        check("rst_a_moved", 32'(a_moved), 0);
        check("rst_b_left",  32'(b_left),  3);
        check("rst_b_right", 32'(b_right), 4);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle for 50 cycles.
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle_left",  32'(a_left),  1);
            check("idle_right", 32'(a_right), 2);
            check("idle_moved", 32'(a_moved), 0);
        end

        // 3-cycle glitch on up is filtered.
        a_up = 1'b1;
        tick(); tick(); tick();
        a_up = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("glitch_left",  32'(a_left),  1);
            check("glitch_moved", 32'(a_moved), 0);
        end

        // Hold up: step at edge 6, then clamped at 2.
        a_up = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            check("up_left",  32'(a_left),  (i >= 6) ? 2 : 1);
            check("up_right", 32'(a_right), (i >= 6) ? 3 : 2);
            check("up_moved", 32'(a_moved), (i == 6) ? 1 : 0);
        end
        a_up = 1'b0;
        repeat (10) tick();

        // Hold down: 2->1 at edge 6, 1->0 at edge 14, then clamped at 0.
        a_dn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            check("dn_left",  32'(a_left),  (i < 6) ? 2 : (i < 14) ? 1 : 0);
            check("dn_moved", 32'(a_moved), (i == 6 || i == 14) ? 1 : 0);
        end

        // Reverse: release down, press up together -> one IDLE cycle then step.
        a_dn = 1'b0;
        a_up = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            check("rev_left",  32'(a_left),  (i < 7) ? 0 : 1);
            check("rev_moved", 32'(a_moved), (i == 7) ? 1 : 0);
            if (i == 7) a_up = 1'b0;
        end
        repeat (5) tick();

        // Move to 2 with a short up press.
        a_up = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("up2_left",  32'(a_left),  (i < 6) ? 1 : 2);
            check("up2_moved", 32'(a_moved), (i == 6) ? 1 : 0);
            if (i == 6) a_up = 1'b0;
        end

        // Both buttons held: no movement.
        a_up = 1'b1;
        a_dn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("both_left",  32'(a_left),  2);
            check("both_moved", 32'(a_moved), 0);
        end

        // Center from 2 -> 1 with one moved pulse.
        a_ctr = 1'b1;
        tick();
        a_ctr = 1'b0;
        check("ctr_left",  32'(a_left),  1);
        check("ctr_right", 32'(a_right), 2);
        check("ctr_moved", 32'(a_moved), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ctr_hold_left",  32'(a_left),  1);
            check("ctr_hold_moved", 32'(a_moved), 0);
        end

        // Center while already centred: no moved pulse.
        a_ctr = 1'b1;
        tick();
        a_ctr = 1'b0;
        check("ctr2_left",  32'(a_left),  1);
        check("ctr2_moved", 32'(a_moved), 0);
        a_up = 1'b0;
        a_dn = 1'b0;
        repeat (10) tick();

        // 8-cell column: up held while frozen, then released from freeze.
        b_frz = 1'b1;
        b_up  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("frz_left",  32'(b_left),  3);
            check("frz_moved", 32'(b_moved), 0);
        end
        b_frz = 1'b0;
        for (int i = 0; i < 25; i++) begin
            int exp_l;
            exp_l = (i < 8) ? 4 : (i < 12) ? 5 : 6;
            tick();
            check("rep_left",  32'(b_left),  exp_l);
            check("rep_right", 32'(b_right), exp_l + 1);
            check("rep_moved", 32'(b_moved), (i == 0 || i == 8 || i == 12) ? 1 : 0);
        end

        // Asynchronous reset mid-move, while moved is high.
        a_up = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        check("pre_rst_left",  32'(a_left),  2);
        check("pre_rst_moved", 32'(a_moved), 1);
        #3 rst = 1'b1;
        #1;
        check("async_a_left",  32'(a_left),  1);
        check("async_a_right", 32'(a_right), 2);
        check("async_a_moved", 32'(a_moved), 0);
        check("async_b_left",  32'(b_left),  3);
        check("async_b_right", 32'(b_right), 4);
        a_up = 1'b0;
        b_up = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_left", 32'(a_left), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/paddle_controller.md
# paddle_controller

Turns one player's raw up/down push-buttons into the paddle's cell range on the LED column. Outputs `state_left` (lowest lit cell) and `state_right` (highest lit cell), which feed the downstream paddle display stage directly. The raw buttons are synchronised and debounced, each press moves the paddle one step, and a held button auto-repeats. The paddle is clamped to the column and can be frozen or re-centred by the game controller.

## Interface
Parameters:
- `WIDTH`, 4: number of cells in the column.
- `BIT_WIDTH`, 2: width of the position outputs; must satisfy 2^BIT_WIDTH >= WIDTH.
- `PADDLE_LEN`, 2: paddle length in cells, from 1 to WIDTH.
- `DEBOUNCE`, 4: number of consecutive stable synchronised samples required before the debounced level changes.
- `REPEAT_DELAY`, 8: cycles from the first step to the first auto-repeat step.
- `REPEAT_PERIOD`, 4: cycles between later auto-repeat steps.
- `CNT_WIDTH`, 8: width of the debounce and repeat counters; must hold max(DEBOUNCE, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- `clk`  in  1  the single clock; everything is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `btn_up`  in  1  raw, asynchronous button; requests an increasing index.
- `btn_down`  in  1  raw, asynchronous button; requests a decreasing index.
- `freeze`  in  1  synchronous; while high the position is held.
- `center`  in  1  synchronous, one-cycle; re-centres the paddle.
- `state_left`  out  BIT_WIDTH  lowest paddle cell, registered.
- `state_right`  out  BIT_WIDTH  equals state_left + PADDLE_LEN - 1, registered.
- `moved`  out  1  one-cycle pulse in the cycle after any position change.

## Operation
- Synchroniser: each button passes through two flops, giving `up_s` and `dn_s`.
- Debounce (one per button):
  - A counter clears whenever the synchronised value equals the debounced value.
  - Otherwise it increments. When it reaches DEBOUNCE-1 and the value still differs, the debounced level takes the new value and the counter clears.
- Direction: `dir = UP` when only up is debounced-high, `DOWN` when only down is, otherwise `NONE`. Both buttons held gives NONE.
- Define `CPOS = (WIDTH-PADDLE_LEN)/2`, using integer division.
- FSM states are IDLE, HOLD and REPEAT.
  - IDLE, dir != NONE: issue one step, load the counter with REPEAT_DELAY-1, go to HOLD.
  - HOLD: if dir differs from the latched direction, go to IDLE with no step. Otherwise decrement; at 0, step, load REPEAT_PERIOD-1, go to REPEAT.
  - REPEAT: same change rule as HOLD. At 0, step and reload REPEAT_PERIOD-1.
  - A direction reversal therefore costs one IDLE cycle and then steps the other way.
- Step:
  - UP: `state_left += 1`, unless `state_left == WIDTH-PADDLE_LEN`.
  - DOWN: `state_left -= 1`, unless it is 0.
  - A clamped step leaves the position unchanged, keeps moved=0, and does not disturb FSM timing.
- Priority, highest first:
  1. `center`: state_left = CPOS, FSM to IDLE. moved pulses only if the position actually changed.
  2. `freeze`: FSM forced to IDLE, no steps. Debounce keeps running.
  3. Normal stepping.
- A button still held when freeze drops steps once immediately, because the FSM enters IDLE with dir != NONE.
- Arithmetic is unsigned, BIT_WIDTH wide. `state_right` is computed and registered together with `state_left` and never wraps, because of the clamp.

## Timing
- Reset values:
  - state_left = CPOS, state_right = CPOS+PADDLE_LEN-1, moved = 0.
  - FSM in IDLE, with all counters, synchroniser flops and debounced levels at 0.
- Latency, with raw press setup before edge E0:
  - The synchronised value is high after E1.
  - The debounced level goes high at edge E1+DEBOUNCE.
  - The position updates at E2+DEBOUNCE, and moved is high for the cycle after that edge.
- Auto-repeat: the next steps land REPEAT_DELAY cycles after the first step, then every REPEAT_PERIOD cycles.
- Glitches shorter than DEBOUNCE synchronised cycles never change the debounced level.
- Reset asserted mid-move returns all outputs to their reset values immediately, with no clock needed. Release is synchronous to the next `clk` edge.

## Test plan
- Reset with defaults (CPOS=1), no buttons pressed -> left=1, right=2, moved=0 for 50 cycles.
- Up pulse of 3 cycles with DEBOUNCE=4 -> no movement and no moved pulse.
- Hold up with defaults -> left becomes 2 at edge 6 and moved pulses once. Then it stays 2 (clamped) with no further moved pulses.
- Set the position to 0, then hold down -> no change, moved stays 0. Releasing down and pressing up -> one step to left=1.
- Both buttons held -> no movement. Then `center` while at left=2 -> left=1 next edge, one moved pulse.
- WIDTH=8, BIT_WIDTH=3, PADDLE_LEN=2, then up held while freeze=1 for 40 cycles:
  - no motion while frozen;
  - freeze drop -> one step next edge;
  - further steps at +8, +12 and +16 cycles;
  - position clamps at left=6.
